acond_sensores: RTL

ACOND_SENSORES -- requirements
Module: acond_sensores

---
 rtl/acond_pkg.sv | 17 +
 rtl/debounce_bit.sv | 39 +++
 rtl/acond_sensores.sv | 73 +++++++
 3 files changed

// File: rtl/acond_pkg.sv
// Shared constants for the sensor conditioning block: bit positions of the
// level probes and pump fault switches, special codes and default timing.
package acond_pkg;

  localparam int LVL_LOW  = 0;
  localparam int LVL_HIGH = 1;
  localparam int FAULT1   = 0;
  localparam int FAULT2   = 1;

  // High probe wet while low probe dry cannot happen with healthy probes.
  localparam logic [1:0] ILLEGAL_LEVEL = 2'b10;
  localparam logic [1:0] P_FAULT2      = 2'b10;

  localparam int PRESC_DEF = 1000;
  localparam int DEB_N_DEF = 4;

endpackage

// File: rtl/debounce_bit.sv
// One debounced input: 2-flop synchronizer followed by a tick-driven
// agreement counter; stable only follows after DEB_N consecutive differing ticks.
module debounce_bit #(
  parameter int DEB_N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEB_N) + 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (tick) begin
        // Any agreeing tick restarts the count, so short glitches never get through.
        if (sync[1] == stable) begin
          cnt <= '0;
        end else if (cnt == CW'(DEB_N - 1)) begin
          stable <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/acond_sensores.sv
// Level-probe and pump-fault conditioning: prescaled debouncing, fault priority
// mapping and optional sticky plausibility check (enabled by ACOND_PLAUS_EN).
module acond_sensores
  import acond_pkg::*;
#(
  parameter int PRESC = PRESC_DEF,
  parameter int DEB_N = DEB_N_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw_a,
  input  logic [1:0] raw_p,
  input  logic       clr_err,
  output logic [1:0] A,
  output logic [1:0] P,
  output logic       err_plaus
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0] presc_cnt;
  logic          tick;
  logic [1:0]    lvl_deb;
  logic [1:0]    flt_deb;

  assign tick = (presc_cnt == PW'(PRESC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PW'(1);
    end
  end

  debounce_bit #(.DEB_N(DEB_N)) u_lvl_low (
    .clk(clk), .reset(reset), .tick(tick), .raw(raw_a[LVL_LOW]), .stable(lvl_deb[LVL_LOW])
  );
  debounce_bit #(.DEB_N(DEB_N)) u_lvl_high (
    .clk(clk), .reset(reset), .tick(tick), .raw(raw_a[LVL_HIGH]), .stable(lvl_deb[LVL_HIGH])
  );
  debounce_bit #(.DEB_N(DEB_N)) u_flt1 (
    .clk(clk), .reset(reset), .tick(tick), .raw(raw_p[FAULT1]), .stable(flt_deb[FAULT1])
  );
  debounce_bit #(.DEB_N(DEB_N)) u_flt2 (
    .clk(clk), .reset(reset), .tick(tick), .raw(raw_p[FAULT2]), .stable(flt_deb[FAULT2])
  );

  // Outputs decode only flop state, never raw inputs; fault 2 wins over fault 1.
  assign P = (flt_deb == 2'b11) ? P_FAULT2 : flt_deb;

`ifdef ACOND_PLAUS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_plaus <= 1'b0;
    end else if (tick && (lvl_deb == ILLEGAL_LEVEL)) begin
      err_plaus <= 1'b1;
    end else if (clr_err) begin
      err_plaus <= 1'b0;
    end
  end

  assign A = err_plaus ? 2'b00 : lvl_deb;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err_plaus      = 1'b0;
  assign A              = lvl_deb;
`endif

endmodule
